// File: rtl/pulse_arb_pkg.sv
// pulse_arb_pkg: shared FSM state encoding and counter width for pulse_channel_arbiter
package pulse_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, FIRE = 2'd2, HOLD = 2'd3} state_t;
    localparam int CNT_W = 16;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search, lowest pending index at or after ptr (wrapping)
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] pending,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] index
);
    logic [W-1:0] w_j;
    // Scan offsets from farthest to nearest so the nearest pending index is assigned last.
    always_comb begin
        index = '0;
        w_j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = W'((int'(ptr) + k) % N);
            if (pending[w_j]) index = w_j;
        end
    end
    assign valid = |pending;
endmodule

// File: rtl/pulse_channel_arbiter.sv
// pulse_channel_arbiter: round-robin arbiter driving a shared pulse + id channel with setup/hold framing.
// Optional coalesced-request counter enabled by defining PULSE_ARB_COALESCE_COUNT_EN.
module pulse_channel_arbiter
    import pulse_arb_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int SETUP_CYCLES = 2,
    parameter  int HOLD_CYCLES  = 4,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] reqIn,
    output logic [NUM_REQ-1:0] pendingOut,
    output logic               pulseOut,
    output logic [ID_W-1:0]    idOut,
    output logic               busyOut,
    output logic [CNT_W-1:0]   coalesceCountOut
);
    localparam int PH_W = $clog2(max2(SETUP_CYCLES, HOLD_CYCLES) + 1);

    state_t             r_state;
    logic [NUM_REQ-1:0] r_pending;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [PH_W-1:0]    r_phase;
    logic               r_pulse;
    logic               r_busy;
    logic               w_valid;
    logic [ID_W-1:0]    w_idx;
    logic [NUM_REQ-1:0] w_grant;

    rr_picker #(.N(NUM_REQ), .W(ID_W)) u_pick (
        .pending(r_pending),
        .ptr    (r_ptr),
        .valid  (w_valid),
        .index  (w_idx)
    );

    assign w_grant = (r_state == IDLE && w_valid) ? (NUM_REQ'(1) << w_idx) : '0;

    // A new request in the grant cycle re-arms the bit, so set wins over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_ptr     <= '0;
            r_id      <= '0;
            r_phase   <= '0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_grant) | reqIn;
            case (r_state)
                IDLE: if (w_valid) begin
                    r_state <= SETUP;
                    r_id    <= w_idx;
                    r_ptr   <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                    r_phase <= PH_W'(SETUP_CYCLES - 1);
                    r_busy  <= 1'b1;
                end
                SETUP: if (r_phase == '0) begin
                    r_state <= FIRE;
                    r_phase <= '0;
                    r_pulse <= 1'b1;
                end else begin
                    r_phase <= r_phase - 1'b1;
                end
                FIRE: begin
                    r_state <= HOLD;
                    r_phase <= PH_W'(HOLD_CYCLES - 1);
                    r_pulse <= 1'b0;
                end
                HOLD: if (r_phase == '0) begin
                    r_state <= IDLE;
                    r_phase <= '0;
                    r_busy  <= 1'b0;
                end else begin
                    r_phase <= r_phase - 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pendingOut = r_pending;
    assign pulseOut   = r_pulse;
    assign idOut      = r_id;
    assign busyOut    = r_busy;

`ifdef PULSE_ARB_COALESCE_COUNT_EN
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (|(reqIn & r_pending & ~w_grant) && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
    assign coalesceCountOut = r_cnt;
`else
    assign coalesceCountOut = '0;
`endif
endmodule

// File: doc/pulse_channel_arbiter.md
PULSE_CHANNEL_ARBITER -- requirements
Module: pulse_channel_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..16.
REQ-002 SHALL have parameter SETUP_CYCLES, default 2: cycles idOut is stable before pulseOut, at least 1.
REQ-003 SHALL have parameter HOLD_CYCLES, default 4: cycles idOut is held after pulseOut, at least 1; sized to at least CLOCK_RATIO + SYNC_STAGES of the downstream pulse synchronizer.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on posedge clk.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port reqIn, input, NUM_REQ: per-requester single-cycle request pulses.
REQ-007 SHALL have port pendingOut, output, NUM_REQ: registered pending request bits.
REQ-008 SHALL have port pulseOut, output, 1: one-cycle pulse to the shared fast-to-slow pulse synchronizer.
REQ-009 SHALL have port idOut, output, ID_W = clog2(NUM_REQ): granted requester index, carried through a multi-bit synchronizer alongside the pulse.
REQ-010 SHALL have port busyOut, output, 1: high whenever the state is not IDLE.
REQ-011 SHALL have port coalesceCountOut, output, 16: count of coalesced requests (see Configuration).

Function
REQ-012 SHALL set pending[i] on reqIn[i]=1, and clear it on the cycle requester i is granted.
REQ-013 SHALL let set win over clear when reqIn[i] coincides with the grant of i, so a new request stays pending.
REQ-014 SHALL run a 4-state FSM: IDLE, SETUP, FIRE, HOLD.
REQ-015 SHALL, in IDLE with any pending bit set, grant round-robin: the lowest index at or after ptr, wrapping modulo NUM_REQ; go to SETUP; load idOut; set ptr = grant+1 mod NUM_REQ.
REQ-016 SHALL stay in IDLE while no pending bit is set, with idOut holding its last value.
REQ-017 SHALL remain in SETUP exactly SETUP_CYCLES cycles, then go to FIRE.
REQ-018 SHALL assert pulseOut=1 only in FIRE, which lasts exactly 1 cycle, then go to HOLD.
REQ-019 SHALL remain in HOLD exactly HOLD_CYCLES cycles, then always return to IDLE for one or more cycles.
REQ-020 SHALL keep idOut constant from SETUP entry through HOLD exit.
REQ-021 SHALL space consecutive pulseOut assertions by at least SETUP_CYCLES+HOLD_CYCLES+2 cycles; this is exact under continuous load.
REQ-022 SHALL have a latency of SETUP_CYCLES+2 cycles from reqIn to pulseOut when idle and no other requester is pending.
REQ-023 SHALL ignore reqIn while the same requester is already pending, apart from the counter in REQ-026; requests never queue deeper than 1 per requester.
REQ-024 SHALL use a phase counter of clog2(max(SETUP_CYCLES,HOLD_CYCLES)+1) bits, reloaded on every state entry.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, set state=IDLE, pending=0, ptr=0, idOut=0, pulseOut=0, busyOut=0 and coalesceCountOut=0; reset mid-operation aborts the transaction and discards pending requests, and reqIn is ignored during reset.

Configuration
REQ-026 SHALL, with PULSE_ARB_COALESCE_COUNT_EN defined, increment coalesceCountOut once per cycle in which any reqIn[i]=1 while pending[i]=1 and i is not granted that cycle, saturating at 16'hFFFF; multiple coalesces in one cycle count as one.
REQ-027 SHALL, with PULSE_ARB_COALESCE_COUNT_EN undefined, drive coalesceCountOut constant 0 and synthesize no counter logic.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE=0, SETUP=1, FIRE=2, HOLD=3) and the 16-bit counter width constant in shared package pulse_arb_pkg.
REQ-029 SHALL implement the round-robin search as sub-module rr_picker (inputs pending and ptr; outputs valid and index), which is purely combinational.

Verification
REQ-030 SHALL check: NUM_REQ=4, SETUP=2, HOLD=4, reqIn=4'b0100 at cycle 0 -> idOut=2 from cycle 2, pulseOut=1 at cycle 4 only, busyOut low at cycle 9.
REQ-031 SHALL check: reqIn=4'b1111 at cycle 0 -> pulses at cycles 4, 12, 20, 28 with idOut 0, 1, 2, 3, then idle.
REQ-032 SHALL check: requester 3 granted last (ptr=0), then reqIn=4'b1001 simultaneously -> grants 0 then 3.
REQ-033 SHALL check: reqIn[1] pulsed 3 times while pending[1]=1 -> a single grant for 1; with the macro coalesceCountOut=3, without it 0.
REQ-034 SHALL check: reqIn[0] in the cycle requester 0 is granted -> pending[0]=1 afterwards and a second pulse for id 0 eight cycles later.
REQ-035 SHALL check: rst=1 during HOLD with pending=4'b0110 -> next cycle IDLE, pending=0, pulseOut=0 and no further pulses.
